// File: rtl/rt_pixel_sequencer.sv
// rt_pixel_sequencer: walks a writable sphere table for each requested pixel,
// drives an external ray-sphere intersector per enabled sphere, keeps the
// nearest hit and emits a shaded pixel over a valid/ready handshake.
module rt_pixel_sequencer #(
    parameter int unsigned CW          = 16,
    parameter int unsigned XW          = 10,
    parameter int unsigned YW          = 9,
    parameter int unsigned NUM_SPHERES = 4,
    parameter int unsigned PIX_W       = 4,
    parameter int unsigned DEPTH_SHIFT = 6,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [1:0]      MODE,
    input  logic [CW-1:0]   F,
    input  logic [3*CW-1:0] CAM,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic [XW-1:0]   X_IN,
    input  logic [YW-1:0]   Y_IN,
    input  logic            SCN_WE,
    input  logic [3:0]      SCN_IDX,
    input  logic [2:0]      SCN_FIELD,
    input  logic [CW-1:0]   SCN_DATA,
    output logic            RSI_START,
    output logic [3*CW-1:0] RSI_P0,
    output logic [3*CW-1:0] RSI_P1,
    output logic [4*CW-1:0] RSI_SPHERE,
    input  logic            RSI_DONE,
    input  logic            RSI_HIT,
    input  logic [CW-1:0]   RSI_HIT_Z,
    output logic            PIX_VALID,
    input  logic            PIX_READY,
    output logic [PIX_W-1:0] PIX_OUT,
    output logic [XW-1:0]   PIX_X,
    output logic [YW-1:0]   PIX_Y,
    output logic            RSI_ERR
);

    localparam int unsigned IW   = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1;
    localparam int unsigned TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned PMAX = (1 << PIX_W) - 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_WAIT  = 3'd2,
        S_SHADE = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t state_q;

    // scene table
    logic [CW-1:0]    cx_q  [NUM_SPHERES];
    logic [CW-1:0]    cy_q  [NUM_SPHERES];
    logic [CW-1:0]    cz_q  [NUM_SPHERES];
    logic [CW-1:0]    rad_q [NUM_SPHERES];
    logic [PIX_W-1:0] col_q [NUM_SPHERES];
    logic [NUM_SPHERES-1:0] en_q;

    // per-pixel working state
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] best_idx_q;
    logic          best_hit_q;
    logic [CW-1:0] best_z_q;
    logic [TW-1:0] timer_q;

    logic             scn_we_c;
    logic [IW-1:0]    scn_idx_c;
    logic             last_c;
    logic [CW-1:0]    depth_c;
    logic [CW-1:0]    step_c;
    logic [PIX_W-1:0] shade_c;

    // Requests are only taken while idle.
    assign REQ_READY = (state_q == S_IDLE);

    assign scn_we_c  = SCN_WE && (state_q == S_IDLE) &&
                       ({1'b0, SCN_IDX} < 5'(NUM_SPHERES));
    assign scn_idx_c = SCN_IDX[IW-1:0];
    assign last_c    = (idx_q == IW'(NUM_SPHERES - 1));

    // Scene table writes; only honoured in IDLE and for in-range indices.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < int'(NUM_SPHERES); i++) begin
                cx_q[i]  <= '0;
                cy_q[i]  <= '0;
                cz_q[i]  <= '0;
                rad_q[i] <= '0;
                col_q[i] <= '0;
            end
            en_q <= '0;
        end else if (scn_we_c) begin
            case (SCN_FIELD)
                3'd0:    cx_q[scn_idx_c]  <= SCN_DATA;
                3'd1:    cy_q[scn_idx_c]  <= SCN_DATA;
                3'd2:    cz_q[scn_idx_c]  <= SCN_DATA;
                3'd3:    rad_q[scn_idx_c] <= SCN_DATA;
                3'd4:    col_q[scn_idx_c] <= SCN_DATA[PIX_W-1:0];
                3'd5:    en_q[scn_idx_c]  <= SCN_DATA[0];
                default: ;
            endcase
        end
    end

    // Shade the nearest hit; MODE is consumed only while in SHADE.
    always_comb begin
        depth_c = '0;
        step_c  = '0;
        shade_c = '0;
        if (best_hit_q) begin
            case (MODE)
                2'd1: begin
                    depth_c = (best_z_q > F) ? (best_z_q - F) : '0;
                    step_c  = depth_c >> DEPTH_SHIFT;
                    if (step_c > CW'(PMAX - 1)) begin
                        step_c = CW'(PMAX - 1);
                    end
                    shade_c = PIX_W'(PMAX) - PIX_W'(step_c);
                end
                2'd2:    shade_c = col_q[best_idx_q];
                default: shade_c = '1;
            endcase
        end
    end

    // Sequencer: scan spheres, wait on the intersector, shade, hand off.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_hit_q <= 1'b0;
            best_z_q   <= '1;
            timer_q    <= '0;
            RSI_START  <= 1'b0;
            RSI_P0     <= '0;
            RSI_P1     <= '0;
            RSI_SPHERE <= '0;
            PIX_VALID  <= 1'b0;
            PIX_OUT    <= '0;
            PIX_X      <= '0;
            PIX_Y      <= '0;
            RSI_ERR    <= 1'b0;
        end else begin
            RSI_START <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (REQ_VALID) begin
                        x_q        <= X_IN;
                        y_q        <= Y_IN;
                        idx_q      <= '0;
                        best_hit_q <= 1'b0;
                        best_z_q   <= '1;
                        state_q    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (en_q[idx_q]) begin
                        RSI_START  <= 1'b1;
                        RSI_P0     <= CAM;
                        RSI_P1     <= {F, CW'(y_q), CW'(x_q)};
                        RSI_SPHERE <= {rad_q[idx_q], cz_q[idx_q], cy_q[idx_q], cx_q[idx_q]};
                        timer_q    <= '0;
                        state_q    <= S_WAIT;
                    end else if (last_c) begin
                        state_q <= S_SHADE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                S_WAIT: begin
                    if (RSI_DONE || (timer_q == TW'(TIMEOUT - 1))) begin
                        if (RSI_DONE) begin
                            if (RSI_HIT && (RSI_HIT_Z < best_z_q)) begin
                                best_hit_q <= 1'b1;
                                best_z_q   <= RSI_HIT_Z;
                                best_idx_q <= idx_q;
                            end
                        end else begin
                            RSI_ERR <= 1'b1;
                        end
                        if (last_c) begin
                            state_q <= S_SHADE;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            state_q <= S_SCAN;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_SHADE: begin
                    PIX_OUT   <= shade_c;
                    PIX_X     <= x_q;
                    PIX_Y     <= y_q;
                    PIX_VALID <= 1'b1;
                    state_q   <= S_OUT;
                end
                S_OUT: begin
                    if (PIX_READY) begin
                        PIX_VALID <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rt_pixel_sequencer.sv
// Self-checking bench for rt_pixel_sequencer: table vectors, hand-written
// corner sequences and randomized pixels against a nearest-hit model.
module tb_rt_pixel_sequencer;

    logic        CLK;
    logic        RESET_N;
    logic [1:0]  MODE;
    logic [15:0] F;
    logic [47:0] CAM;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [9:0]  X_IN;
    logic [8:0]  Y_IN;
    logic        SCN_WE;
    logic [3:0]  SCN_IDX;
    logic [2:0]  SCN_FIELD;
    logic [15:0] SCN_DATA;
    logic        RSI_START;
    logic [47:0] RSI_P0;
    logic [47:0] RSI_P1;
    logic [63:0] RSI_SPHERE;
    logic        RSI_DONE;
    logic        RSI_HIT;
    logic [15:0] RSI_HIT_Z;
    logic        PIX_VALID;
    logic        PIX_READY;
    logic [3:0]  PIX_OUT;
    logic [9:0]  PIX_X;
    logic [8:0]  PIX_Y;
    logic        RSI_ERR;

    rt_pixel_sequencer dut (
        .CLK(CLK), .RESET_N(RESET_N), .MODE(MODE), .F(F), .CAM(CAM),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .X_IN(X_IN), .Y_IN(Y_IN),
        .SCN_WE(SCN_WE), .SCN_IDX(SCN_IDX), .SCN_FIELD(SCN_FIELD), .SCN_DATA(SCN_DATA),
        .RSI_START(RSI_START), .RSI_P0(RSI_P0), .RSI_P1(RSI_P1), .RSI_SPHERE(RSI_SPHERE),
        .RSI_DONE(RSI_DONE), .RSI_HIT(RSI_HIT), .RSI_HIT_Z(RSI_HIT_Z),
        .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY), .PIX_OUT(PIX_OUT),
        .PIX_X(PIX_X), .PIX_Y(PIX_Y), .RSI_ERR(RSI_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // intersector model controls (written by the main process only)
    logic [3:0]  rsp_hit;
    logic [15:0] rsp_z [4];
    bit          rsi_mute = 1'b0;
    int          rsi_lat  = 3;
    // intersector observations (written by the intersector process only)
    int          start_cnt    = 0;
    int          unstable_cnt = 0;
    logic [63:0] cap_sph;
    logic [47:0] cap_p0;
    logic [47:0] cap_p1;

    int col_m [4] = '{5, 3, 9, 12};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Intersector: answers each start after rsi_lat cycles, keyed on cx = sphere index.
    initial begin : rsi_model
        logic [1:0] key;
        RSI_DONE  = 1'b0;
        RSI_HIT   = 1'b0;
        RSI_HIT_Z = '0;
        forever begin
            @(negedge CLK);
            if (RSI_START === 1'b1) begin
                start_cnt++;
                cap_sph = RSI_SPHERE;
                cap_p0  = RSI_P0;
                cap_p1  = RSI_P1;
                key     = RSI_SPHERE[1:0];
                if (!rsi_mute) begin
                    repeat (rsi_lat - 1) begin
                        @(negedge CLK);
                        if (RSI_SPHERE !== cap_sph || RSI_P0 !== cap_p0 || RSI_P1 !== cap_p1)
                            unstable_cnt++;
                    end
                    RSI_DONE  = 1'b1;
                    RSI_HIT   = rsp_hit[key];
                    RSI_HIT_Z = rsp_z[key];
                    @(negedge CLK);
                    RSI_DONE  = 1'b0;
                    RSI_HIT   = 1'b0;
                end
            end
        end
    end

    // Reference: nearest enabled hit (first index wins ties), then shade by mode.
    function automatic int model_pix(input logic [3:0] en, input int mode, input int f);
        int best = -1;
        int bz   = 0;
        int d;
        int s;
        for (int i = 0; i < 4; i++) begin
            if (en[i] && rsp_hit[i] && (best < 0 || int'(rsp_z[i]) < bz)) begin
                best = i;
                bz   = int'(rsp_z[i]);
            end
        end
        if (best < 0) return 0;
        if (mode == 1) begin
            d = (bz > f) ? bz - f : 0;
            s = d / 64;
            if (s > 14) s = 14;
            return 15 - s;
        end
        if (mode == 2) return col_m[best];
        return 15;
    endfunction

    task automatic scn_write(input int idx, input int field, input int data);
        SCN_WE    = 1'b1;
        SCN_IDX   = 4'(idx);
        SCN_FIELD = 3'(field);
        SCN_DATA  = 16'(data);
        @(negedge CLK);
        SCN_WE    = 1'b0;
    endtask

    task automatic apply_en(input logic [3:0] mask);
        for (int i = 0; i < 4; i++) scn_write(i, 5, int'(mask[i]));
    endtask

    // Issue one request; returns at the negedge PIX_VALID is first seen (and
    // one negedge later if PIX_READY already completes the handshake).
    // lat counts negedges after the acceptance edge, the first one being 1.
    task automatic run_pixel(input logic [9:0] x, input logic [8:0] y,
                             output logic [3:0] pix, output logic [9:0] px,
                             output logic [8:0] py, output int lat, output int starts);
        int s0;
        s0 = start_cnt;
        chk("req_ready_before_req", 64'(REQ_READY), 64'(1));
        REQ_VALID = 1'b1;
        X_IN      = x;
        Y_IN      = y;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        SCN_WE    = 1'b0;
        lat       = 1;
        while (PIX_VALID !== 1'b1 && lat < 2000) begin
            @(negedge CLK);
            lat++;
        end
        chk("pix_valid_seen", 64'(PIX_VALID), 64'(1));
        pix    = PIX_OUT;
        px     = PIX_X;
        py     = PIX_Y;
        starts = start_cnt - s0;
        if (PIX_READY) @(negedge CLK);
    endtask

    typedef struct {
        logic [3:0]  en;
        logic [1:0]  mode;
        logic [15:0] f;
        logic [3:0]  hit;
        logic [15:0] z0, z1, z2, z3;
        logic [3:0]  exp_pix;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    logic [3:0] pix;
    logic [9:0] px;
    logic [8:0] py;
    int         lat;
    int         st;
    int         exp_i;

    initial begin
        vecs[0]  = '{4'b0000, 2'd0, 16'd0,    4'b0000, 16'd0,   16'd0,    16'd0,    16'd0,    4'h0};
        vecs[1]  = '{4'b0001, 2'd0, 16'd777,  4'b0001, 16'd1000, 16'd0,   16'd0,    16'd0,    4'hF};
        vecs[2]  = '{4'b0110, 2'd2, 16'd0,    4'b0110, 16'd0,   16'd1200, 16'd1100, 16'd0,    4'd9};
        vecs[3]  = '{4'b0110, 2'd2, 16'd0,    4'b0110, 16'd0,   16'd1100, 16'd1100, 16'd0,    4'd3};
        vecs[4]  = '{4'b0001, 2'd1, 16'd1000, 4'b0001, 16'd1128, 16'd0,   16'd0,    16'd0,    4'd13};
        vecs[5]  = '{4'b0001, 2'd1, 16'd1000, 4'b0001, 16'd900, 16'd0,    16'd0,    16'd0,    4'd15};
        vecs[6]  = '{4'b0001, 2'd1, 16'd1000, 4'b0001, 16'd5000, 16'd0,   16'd0,    16'd0,    4'd1};
        vecs[7]  = '{4'b1111, 2'd0, 16'd0,    4'b0000, 16'd0,   16'd0,    16'd0,    16'd0,    4'h0};
        vecs[8]  = '{4'b1000, 2'd3, 16'd0,    4'b1000, 16'd0,   16'd0,    16'd0,    16'd77,   4'hF};
        vecs[9]  = '{4'b1001, 2'd2, 16'd0,    4'b1001, 16'd500, 16'd0,    16'd0,    16'd400,  4'd12};
        vecs[10] = '{4'b0101, 2'd2, 16'd0,    4'b0100, 16'd0,   16'd0,    16'd7,    16'd0,    4'd9};
        vecs[11] = '{4'b1111, 2'd1, 16'd100,  4'b1111, 16'd900, 16'd300,  16'd200,  16'd2000, 4'd14};
        vecs[12] = '{4'b0010, 2'd2, 16'd0,    4'b0011, 16'd1,   16'd500,  16'd0,    16'd0,    4'd3};

        RESET_N   = 1'b0;
        MODE      = 2'd0;
        F         = '0;
        CAM       = {16'd30, 16'd20, 16'd10};
        REQ_VALID = 1'b0;
        X_IN      = '0;
        Y_IN      = '0;
        SCN_WE    = 1'b0;
        SCN_IDX   = '0;
        SCN_FIELD = '0;
        SCN_DATA  = '0;
        PIX_READY = 1'b1;
        rsp_hit   = '0;
        for (int i = 0; i < 4; i++) rsp_z[i] = '0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);

        // reset state
        chk("rst_req_ready", 64'(REQ_READY), 64'(1));
        chk("rst_pix_valid", 64'(PIX_VALID), 64'(0));
        chk("rst_pix_out",   64'(PIX_OUT),   64'(0));
        chk("rst_pix_x",     64'(PIX_X),     64'(0));
        chk("rst_pix_y",     64'(PIX_Y),     64'(0));
        chk("rst_rsi_err",   64'(RSI_ERR),   64'(0));
        chk("rst_rsi_start", 64'(RSI_START), 64'(0));

        // empty scene: latency NUM_SPHERES+2, no intersector activity
        run_pixel(10'd5, 9'd7, pix, px, py, lat, st);
        chk("empty_latency", 64'(lat), 64'(6));
        chk("empty_pix",     64'(pix), 64'(0));
        chk("empty_x",       64'(px),  64'(5));
        chk("empty_y",       64'(py),  64'(7));
        chk("empty_starts",  64'(st),  64'(0));

        // static sphere geometry and colours
        for (int i = 0; i < 4; i++) begin
            scn_write(i, 0, i);
            scn_write(i, 1, 100 + i);
            scn_write(i, 2, 200 + i);
            scn_write(i, 3, 50 + i);
            scn_write(i, 4, col_m[i]);
        end

        // table vectors
        for (int i = 0; i < NV; i++) begin
            apply_en(vecs[i].en);
            rsp_hit  = vecs[i].hit;
            rsp_z[0] = vecs[i].z0;
            rsp_z[1] = vecs[i].z1;
            rsp_z[2] = vecs[i].z2;
            rsp_z[3] = vecs[i].z3;
            MODE     = vecs[i].mode;
            F        = vecs[i].f;
            run_pixel(10'(i * 3 + 1), 9'(i * 2 + 2), pix, px, py, lat, st);
            chk($sformatf("vec%0d_pix", i),    64'(pix), 64'(vecs[i].exp_pix));
            chk($sformatf("vec%0d_x", i),      64'(px),  64'(i * 3 + 1));
            chk($sformatf("vec%0d_y", i),      64'(py),  64'(i * 2 + 2));
            chk($sformatf("vec%0d_starts", i), 64'(st),  64'($countones(vecs[i].en)));
            if (i == 1) begin
                chk("vec1_sphere", cap_sph, {16'd50, 16'd200, 16'd100, 16'd0});
                chk("vec1_p0",     64'(cap_p0), 64'({16'd30, 16'd20, 16'd10}));
                chk("vec1_p1",     64'(cap_p1), 64'({16'd777, 16'd4, 16'd4}));
            end
        end
        chk("rsi_inputs_stable", 64'(unstable_cnt), 64'(0));

        // back-pressure: outputs hold, and a scene write in OUT is dropped
        apply_en(4'b0001);
        rsp_hit  = 4'b0001;
        rsp_z[0] = 16'd10;
        MODE     = 2'd0;
        PIX_READY = 1'b0;
        run_pixel(10'd100, 9'd200, pix, px, py, lat, st);
        chk("bp_pix", 64'(pix), 64'hF);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                SCN_WE = 1'b1; SCN_IDX = 4'd3; SCN_FIELD = 3'd5; SCN_DATA = 16'd1;
            end
            @(negedge CLK);
            SCN_WE = 1'b0;
            chk($sformatf("bp_valid_%0d", k),     64'(PIX_VALID), 64'(1));
            chk($sformatf("bp_out_%0d", k),       64'(PIX_OUT),   64'hF);
            chk($sformatf("bp_req_ready_%0d", k), 64'(REQ_READY), 64'(0));
        end
        PIX_READY = 1'b1;
        @(negedge CLK);
        chk("bp_valid_drop", 64'(PIX_VALID), 64'(0));
        chk("bp_idle_ready", 64'(REQ_READY), 64'(1));
        rsp_hit  = 4'b1000;
        rsp_z[3] = 16'd1;
        MODE     = 2'd2;
        run_pixel(10'd9, 9'd9, pix, px, py, lat, st);
        chk("dropped_write_pix",    64'(pix), 64'(0));
        chk("dropped_write_starts", 64'(st),  64'(1));

        // out-of-range scene indices are ignored
        apply_en(4'b0000);
        scn_write(4, 5, 1);
        scn_write(5, 5, 1);
        rsp_hit = 4'b1111;
        MODE    = 2'd0;
        run_pixel(10'd8, 9'd8, pix, px, py, lat, st);
        chk("oor_idx_pix",    64'(pix), 64'(0));
        chk("oor_idx_starts", 64'(st),  64'(0));

        // write and request on the same edge: the new pixel sees the write
        rsp_hit  = 4'b0001;
        rsp_z[0] = 16'd50;
        SCN_WE = 1'b1; SCN_IDX = 4'd0; SCN_FIELD = 3'd5; SCN_DATA = 16'd1;
        run_pixel(10'd6, 9'd6, pix, px, py, lat, st);
        chk("same_edge_pix",    64'(pix), 64'hF);
        chk("same_edge_starts", 64'(st),  64'(1));

        // randomized pixels against the reference model
        for (int it = 0; it < 40; it++) begin
            logic [3:0] en;
            en = 4'($urandom_range(0, 15));
            apply_en(en);
            rsp_hit = 4'($urandom);
            for (int i = 0; i < 4; i++) rsp_z[i] = 16'($urandom_range(0, 7) * 700);
            F       = 16'($urandom_range(0, 3000));
            MODE    = 2'($urandom);
            rsi_lat = int'($urandom_range(1, 4));
            X_IN    = 10'($urandom);
            exp_i   = model_pix(en, int'(MODE), int'(F));
            run_pixel(10'($urandom), 9'($urandom), pix, px, py, lat, st);
            chk($sformatf("rnd%0d_pix", it),    64'(pix), 64'(exp_i));
            chk($sformatf("rnd%0d_x", it),      64'(px),  64'(X_IN));
            chk($sformatf("rnd%0d_y", it),      64'(py),  64'(Y_IN));
            chk($sformatf("rnd%0d_starts", it), 64'(st),  64'($countones(en)));
        end
        rsi_lat = 3;
        chk("rnd_rsi_inputs_stable", 64'(unstable_cnt), 64'(0));

        // intersector never answers: miss after 255 WAIT cycles, sticky error
        apply_en(4'b0001);
        rsi_mute = 1'b1;
        MODE     = 2'd0;
        chk("err_before_timeout", 64'(RSI_ERR), 64'(0));
        run_pixel(10'd11, 9'd12, pix, px, py, lat, st);
        chk("timeout_latency", 64'(lat),     64'(261));
        chk("timeout_pix",     64'(pix),     64'(0));
        chk("timeout_err",     64'(RSI_ERR), 64'(1));
        rsi_mute = 1'b0;
        rsp_hit  = 4'b0001;
        rsp_z[0] = 16'd10;
        run_pixel(10'd33, 9'd44, pix, px, py, lat, st);
        chk("post_timeout_pix", 64'(pix),     64'hF);
        chk("err_sticky",       64'(RSI_ERR), 64'(1));

        // asynchronous reset in the middle of WAIT
        rsi_mute  = 1'b1;
        REQ_VALID = 1'b1;
        X_IN      = 10'd77;
        Y_IN      = 9'd88;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        repeat (20) @(negedge CLK);
        chk("mid_wait_busy", 64'(REQ_READY), 64'(0));
        RESET_N = 1'b0;
        #1;
        chk("arst_req_ready", 64'(REQ_READY), 64'(1));
        chk("arst_pix_valid", 64'(PIX_VALID), 64'(0));
        chk("arst_pix_out",   64'(PIX_OUT),   64'(0));
        chk("arst_pix_x",     64'(PIX_X),     64'(0));
        chk("arst_pix_y",     64'(PIX_Y),     64'(0));
        chk("arst_rsi_err",   64'(RSI_ERR),   64'(0));
        chk("arst_rsi_start", 64'(RSI_START), 64'(0));
        @(negedge CLK);
        RESET_N  = 1'b1;
        rsi_mute = 1'b0;
        @(negedge CLK);

        // scene table cleared by reset: nothing is enabled
        rsp_hit = 4'b1111;
        run_pixel(10'd1, 9'd1, pix, px, py, lat, st);
        chk("post_rst_starts", 64'(st),  64'(0));
        chk("post_rst_pix",    64'(pix), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rt_pixel_sequencer.md
Name: rt_pixel_sequencer

Overview:
Parametrised successor to the single-sphere pixel core. It accepts pixel requests over a valid/ready handshake and holds a writable scene table of NUM_SPHERES spheres. For each sphere it drives an external ray-sphere intersector and keeps the nearest hit. It then emits a shaded pixel over a second valid/ready handshake, and sits between the VGA pixel scheduler and the intersector.

Parameters:
CW, 16, scene coordinate, focal-length and depth width
XW, 10, pixel X width
YW, 9, pixel Y width
NUM_SPHERES, 4, scene table depth (1..16)
PIX_W, 4, output pixel width
DEPTH_SHIFT, 6, right shift applied to depth in MODE 1
TIMEOUT, 255, maximum intersector wait in cycles

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous active-low reset
MODE  in  2  0 binary, 1 depth-shaded, 2 per-sphere colour, 3 treated as 0
F  in  CW  focal length (screen z)
CAM  in  3*CW  camera {z,y,x}
REQ_VALID  in  1  pixel request valid
REQ_READY  out  1  request accepted when valid and ready are both high
X_IN  in  XW  pixel X
Y_IN  in  YW  pixel Y
SCN_WE  in  1  scene write strobe
SCN_IDX  in  4  sphere index
SCN_FIELD  in  3  0 cx, 1 cy, 2 cz, 3 radius, 4 colour (low PIX_W bits), 5 enable (bit 0)
SCN_DATA  in  CW  write data
RSI_START  out  1  one-cycle intersector start pulse
RSI_P0  out  3*CW  ray origin (CAM)
RSI_P1  out  3*CW  ray target {F, Y, X}, zero-extended
RSI_SPHERE  out  4*CW  {r,cz,cy,cx} of the current sphere
RSI_DONE  in  1  intersector result valid
RSI_HIT  in  1  collision flag
RSI_HIT_Z  in  CW  z of the near intersection
PIX_VALID  out  1  output pixel valid
PIX_READY  in  1  downstream accepts the pixel
PIX_OUT  out  PIX_W  shaded pixel
PIX_X  out  XW  echoed X
PIX_Y  out  YW  echoed Y
RSI_ERR  out  1  sticky timeout flag

Behaviour:
- Reset (asynchronous): state IDLE. Scene table all zero, so every sphere is disabled. RSI_START=0, PIX_VALID=0, PIX_OUT=0, PIX_X=0, PIX_Y=0, RSI_ERR=0. REQ_READY=1 once reset deasserts.
- Reset mid-operation: abort immediately to the reset values. An in-flight intersector result arriving later is ignored because RSI_DONE is sampled only in WAIT.
- REQ_READY is 1 only in IDLE; it is combinational from state.
- Scene writes take effect only in IDLE. Writes in any other state are dropped. A write and a request accepted on the same edge: the write takes effect and the new pixel sees the new value. SCN_IDX >= NUM_SPHERES is ignored.
- States:
  - IDLE: on request acceptance, latch X/Y, idx=0, best_hit=0, best_z=all-ones; go to SCAN.
  - SCAN: if sphere[idx] is enabled, pulse RSI_START for one cycle, clear the timer, and go to WAIT. Otherwise skip: if idx is last, go to SHADE; else idx+1 and stay in SCAN.
  - WAIT: on RSI_DONE, if RSI_HIT && RSI_HIT_Z < best_z (strict, so the lower index wins a tie), set best_hit=1, best_z=RSI_HIT_Z, best_idx=idx. Then go to SHADE if idx is last, else SCAN with idx+1. If the timer reaches TIMEOUT without RSI_DONE, treat the sphere as a miss, set RSI_ERR, and advance the same way.
  - SHADE: compute PIX_OUT, register PIX_X/PIX_Y, set PIX_VALID, go to OUT.
  - OUT: hold all outputs stable while PIX_READY=0. On PIX_READY, drop PIX_VALID and go to IDLE.
- RSI_P0, RSI_P1 and RSI_SPHERE are stable from RSI_START until RSI_DONE or timeout.
- Shading when best_hit=0: PIX_OUT=0.
- Shading when best_hit=1:
  - MODE 0/3: all-ones.
  - MODE 1: d = best_z - F, saturating at 0. PIX_OUT = (2^PIX_W - 1) - min(d >> DEPTH_SHIFT, 2^PIX_W - 2), so a hit never shades to 0.
  - MODE 2: colour[best_idx].
- MODE is sampled in SHADE.
- Latency with all spheres disabled: PIX_VALID high NUM_SPHERES+2 cycles after the acceptance edge.
- RSI_ERR clears only on reset.

Test Plan:
- Reset, no writes; request (5,7), PIX_READY=1 -> PIX_VALID 6 cycles after acceptance, PIX_OUT=0, PIX_X=5, PIX_Y=7, RSI_START never pulses.
- Sphere 0 enabled, MODE 0; intersector model answers HIT=1, Z=1000 after 3 cycles -> exactly one RSI_START, RSI_SPHERE matches the written fields, PIX_OUT=4'hF.
- Spheres 1 and 2 enabled with colours 3 and 9, MODE 2; hits at Z=1200 and Z=1100 -> PIX_OUT=9. With both at Z=1100 -> PIX_OUT=3 (tie, lower index).
- MODE 1, F=1000, hit Z=1128 -> d>>6=2, PIX_OUT=13. Hit Z=900 -> PIX_OUT=15. Hit Z=5000 -> PIX_OUT=1.
- Hold PIX_READY=0 for 5 cycles -> PIX_VALID and PIX_OUT stable, REQ_READY=0. A scene write issued during this window is dropped (read back by a later pixel).
- Intersector never asserts RSI_DONE, TIMEOUT=255 -> miss after 255 WAIT cycles, RSI_ERR=1, PIX_OUT=0. Pull RESET_N low mid-WAIT -> all outputs at reset values asynchronously.
